uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 250 +++++++++++++++++++++++++
 tb/tb_uart_rx.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: 2-flop input synchronizer, start-bit validation at
// mid-bit, 8 data bits LSB first, optional parity, one stop bit.
// The received word is held in UARTDR with rdy/perr/ferr until the
// consumer acknowledges it; a frame that completes while the previous
// one is still unread is dropped and flagged with the sticky ovr bit.
module uart_rx #(
    parameter logic [15:0] BIT_CYCLES  = 16'h0364,
    parameter logic [15:0] HALF_CYCLES = BIT_CYCLES / 16'd2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rxd,
    input  logic        parity_en,
    input  logic        parity_kind,
    input  logic        rd_ack,
    output logic [15:0] UARTDR,
    output logic        rdy,
    output logic        perr,
    output logic        ferr,
    output logic        ovr,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    localparam logic [15:0] BIT_LAST  = BIT_CYCLES - 16'd1;
    localparam logic [15:0] HALF_LAST = HALF_CYCLES - 16'd1;

    // True when data plus received parity bit disagree with the expected kind
    // (kind 1 = odd: total number of ones including the parity bit is odd).
    function automatic logic parity_mismatch(
        input logic [7:0] data,
        input logic       pbit,
        input logic       kind
    );
        return ((^data) ^ pbit) != kind;
    endfunction

    // Synchronizer and line-qualification state
    logic        rxd_meta_q, rxd_meta_d;
    logic        rxd_sync_q, rxd_sync_d;
    logic [1:0]  sync_vld_q, sync_vld_d;
    logic        armed_q, armed_d;
    logic        rxd_s;

    // Frame FSM state
    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        par_en_q, par_en_d;
    logic        par_kind_q, par_kind_d;
    logic        perr_cand_q, perr_cand_d;
    logic        ferr_cand_q, ferr_cand_d;
    logic        done_q, done_d;

    // Output holding registers
    logic [7:0]  word_q, word_d;
    logic        rdy_q, rdy_d;
    logic        perr_q, perr_d;
    logic        ferr_q, ferr_d;
    logic        ovr_q, ovr_d;
    logic        busy_q, busy_d;

    assign rxd_s = rxd_sync_q;

    // Synchronizer next values; sync_vld marks when rxd_s reflects a real post-reset sample
    always_comb begin
        rxd_meta_d = rxd;
        rxd_sync_d = rxd_meta_q;
        sync_vld_d = {sync_vld_q[0], 1'b1};
    end

    // Frame FSM: next state, bit timing, sampling and per-frame latches
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        par_en_d    = par_en_q;
        par_kind_d  = par_kind_q;
        perr_cand_d = perr_cand_q;
        ferr_cand_d = ferr_cand_q;
        armed_d     = armed_q;
        done_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = 16'd0;
                idx_d = 3'd0;
                if (sync_vld_q[1] == 1'b0) begin
                    // synchronizer still holds reset values; the line is unknown
                    armed_d = 1'b0;
                end else if (rxd_s == 1'b1) begin
                    armed_d = 1'b1;
                end else if (armed_q == 1'b1) begin
                    // 1->0 transition on a line previously seen high
                    state_d    = S_START;
                    armed_d    = 1'b0;
                    par_en_d   = parity_en;
                    par_kind_d = parity_kind;
                end else begin
                    armed_d = 1'b0;
                end
            end
            S_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = 16'd0;
                    if (rxd_s == 1'b1) begin
                        // glitch: line back high at mid start bit
                        state_d = S_IDLE;
                        armed_d = 1'b1;
                    end else begin
                        state_d     = S_DATA;
                        idx_d       = 3'd0;
                        perr_cand_d = 1'b0;
                        ferr_cand_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d          = 16'd0;
                    shift_d[idx_q] = rxd_s;
                    if (idx_q == 3'd7) begin
                        idx_d   = 3'd0;
                        state_d = par_en_q ? S_PARITY : S_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_PARITY: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d       = 16'd0;
                    perr_cand_d = par_en_q & parity_mismatch(shift_q, rxd_s, par_kind_q);
                    state_d     = S_STOP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d       = 16'd0;
                    ferr_cand_d = ~rxd_s;
                    done_d      = 1'b1;
                    state_d     = S_IDLE;
                    // a low stop bit leaves the line unqualified until it returns high
                    armed_d     = rxd_s;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 16'd0;
                idx_d   = 3'd0;
                armed_d = 1'b0;
            end
        endcase
    end

    // Completion and consumer handshake: load, overrun, acknowledge
    always_comb begin
        word_d = word_q;
        rdy_d  = rdy_q;
        perr_d = perr_q;
        ferr_d = ferr_q;
        ovr_d  = ovr_q;
        busy_d = (state_d != S_IDLE);
        if (done_q == 1'b1) begin
            if ((rdy_q == 1'b0) || (rd_ack == 1'b1)) begin
                word_d = shift_q;
                perr_d = perr_cand_q;
                ferr_d = ferr_cand_q;
                rdy_d  = 1'b1;
                ovr_d  = rd_ack ? 1'b0 : ovr_q;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (rd_ack == 1'b1) begin
            rdy_d = 1'b0;
            ovr_d = 1'b0;
        end else begin
            rdy_d = rdy_q;
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_meta_q  <= 1'b1;
            rxd_sync_q  <= 1'b1;
            sync_vld_q  <= 2'b00;
            armed_q     <= 1'b0;
            state_q     <= S_IDLE;
            cnt_q       <= 16'd0;
            idx_q       <= 3'd0;
            shift_q     <= 8'h00;
            par_en_q    <= 1'b0;
            par_kind_q  <= 1'b0;
            perr_cand_q <= 1'b0;
            ferr_cand_q <= 1'b0;
            done_q      <= 1'b0;
            word_q      <= 8'h00;
            rdy_q       <= 1'b0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
            ovr_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            rxd_meta_q  <= rxd_meta_d;
            rxd_sync_q  <= rxd_sync_d;
            sync_vld_q  <= sync_vld_d;
            armed_q     <= armed_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            par_en_q    <= par_en_d;
            par_kind_q  <= par_kind_d;
            perr_cand_q <= perr_cand_d;
            ferr_cand_q <= ferr_cand_d;
            done_q      <= done_d;
            word_q      <= word_d;
            rdy_q       <= rdy_d;
            perr_q      <= perr_d;
            ferr_q      <= ferr_d;
            ovr_q       <= ovr_d;
            busy_q      <= busy_d;
        end
    end

    assign UARTDR = {8'h00, word_q};
    assign rdy    = rdy_q;
    assign perr   = perr_q;
    assign ferr   = ferr_q;
    assign ovr    = ovr_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx with BIT_CYCLES=16, HALF_CYCLES=8. Frames are driven
// bit by bit on the negative clock edge; expected holding-register contents
// come from a small model of the receive/acknowledge rules.
module tb_uart_rx;

    localparam int B = 16;
    localparam int H = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rxd = 1'b1;
    logic        parity_en = 1'b0;
    logic        parity_kind = 1'b0;
    logic        rd_ack = 1'b0;
    logic [15:0] UARTDR;
    logic        rdy, perr, ferr, ovr, busy;

    int errors = 0;
    int checks = 0;

    // reference model of the consumer-visible state
    logic [7:0] m_word = 8'h00;
    logic       m_rdy = 1'b0, m_perr = 1'b0, m_ferr = 1'b0, m_ovr = 1'b0;

    always #5 clk = ~clk;

    uart_rx #(.BIT_CYCLES(16'd16), .HALF_CYCLES(16'd8)) dut (
        .clk(clk), .rst_n(rst_n), .rxd(rxd), .parity_en(parity_en),
        .parity_kind(parity_kind), .rd_ack(rd_ack), .UARTDR(UARTDR),
        .rdy(rdy), .perr(perr), .ferr(ferr), .ovr(ovr), .busy(busy)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // expected parity error: count ones in data plus parity bit
    function automatic logic exp_perr(input logic [7:0] d, input logic pe, input logic kind, input logic pbit);
        int ones;
        ones = $countones(d) + int'(pbit);
        return pe && ((ones % 2) != int'(kind));
    endfunction

    task automatic model_complete(input logic [7:0] d, input logic pe_err, input logic fe, input logic ack_same);
        if (!m_rdy || ack_same) begin
            m_word = d; m_perr = pe_err; m_ferr = fe; m_rdy = 1'b1;
        end else begin
            m_ovr = 1'b1;
        end
        if (ack_same) m_ovr = 1'b0;
    endtask

    task automatic model_ack();
        m_rdy = 1'b0;
        m_ovr = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] data, input logic with_par, input logic pbit, input logic stop);
        @(negedge clk);
        rxd = 1'b0;
        repeat (B) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = data[i];
            repeat (B) @(negedge clk);
        end
        if (with_par) begin
            rxd = pbit;
            repeat (B) @(negedge clk);
        end
        rxd = stop;
        repeat (B) @(negedge clk);
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_ack();
        @(negedge clk);
        rd_ack = 1'b1;
        @(negedge clk);
        rd_ack = 1'b0;
    endtask

    // cycles from the falling start edge until rdy is seen, and busy at that moment
    task automatic measure(output int lat, output logic b_at);
        lat = -1;
        b_at = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            if (rdy === 1'b1) begin
                lat = i;
                b_at = busy;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rxd = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (UARTDR !== 16'h0000) begin errors++; $display("FAIL reset_word: got %h want 0000", UARTDR); end
        checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL reset_rdy: got %b want 0", rdy); end
        checks++; if ({perr, ferr, ovr, busy} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b want 0000", {perr, ferr, ovr, busy}); end
        rst_n = 1'b1;
        idle(10);
    endtask

    task automatic test_8n1();
        int lat;
        logic b_at;
        parity_en = 1'b0;
        fork
            send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
            measure(lat, b_at);
        join
        idle(4);
        model_complete(8'hA5, 1'b0, 1'b0, 1'b0);
        checks++; if (lat !== H + 9 * B + 3) begin errors++; $display("FAIL 8n1_latency: got %0d want %0d", lat, H + 9 * B + 3); end
        checks++; if (b_at !== 1'b0) begin errors++; $display("FAIL 8n1_busy_at_rdy: got %b want 0", b_at); end
        checks++; if (UARTDR !== 16'h00A5) begin errors++; $display("FAIL 8n1_word: got %h want 00a5", UARTDR); end
        checks++; if ({rdy, perr, ferr, busy} !== 4'b1000) begin errors++; $display("FAIL 8n1_flags: got %b want 1000", {rdy, perr, ferr, busy}); end
        pulse_ack();
        model_ack();
        checks++; if (rdy !== 1'b0 || UARTDR !== 16'h00A5) begin errors++; $display("FAIL 8n1_ack: got rdy=%b word=%h want rdy=0 word=00a5", rdy, UARTDR); end
    endtask

    task automatic test_parity();
        int lat;
        logic b_at;
        parity_en = 1'b1;
        parity_kind = 1'b1;
        fork
            send_frame(8'h03, 1'b1, 1'b1, 1'b1);
            measure(lat, b_at);
        join
        idle(4);
        checks++; if (lat !== H + 10 * B + 3 || b_at !== 1'b0) begin errors++; $display("FAIL odd_latency: got %0d busy=%b want %0d busy=0", lat, b_at, H + 10 * B + 3); end
        checks++; if (UARTDR !== 16'h0003 || perr !== 1'b0 || ferr !== 1'b0) begin errors++; $display("FAIL odd_good: got word=%h perr=%b ferr=%b want 0003 0 0", UARTDR, perr, ferr); end
        pulse_ack();
        model_ack();
        // parity settings change mid-frame; the receiver must keep the latched ones
        fork
            send_frame(8'h03, 1'b1, 1'b0, 1'b1);
            begin
                repeat (40) @(negedge clk);
                parity_en = 1'b0;
                parity_kind = 1'b0;
            end
        join
        idle(4);
        model_complete(8'h03, exp_perr(8'h03, 1'b1, 1'b1, 1'b0), 1'b0, 1'b0);
        checks++; if (UARTDR !== 16'h0003 || perr !== 1'b1 || ferr !== 1'b0 || rdy !== 1'b1) begin errors++; $display("FAIL odd_bad: got word=%h perr=%b ferr=%b rdy=%b want 0003 1 0 1", UARTDR, perr, ferr, rdy); end
        pulse_ack();
        model_ack();
    endtask

    task automatic test_glitch();
        logic saw;
        saw = 1'b0;
        @(negedge clk);
        rxd = 1'b0;
        for (int i = 0; i < 4; i++) begin @(negedge clk); saw = saw | busy; end
        rxd = 1'b1;
        for (int i = 0; i < 30; i++) begin @(negedge clk); saw = saw | busy; end
        checks++; if (saw !== 1'b1) begin errors++; $display("FAIL glitch_start_seen: got %b want 1", saw); end
        checks++; if ({rdy, busy} !== {m_rdy, 1'b0}) begin errors++; $display("FAIL glitch_idle: got rdy=%b busy=%b want %b 0", rdy, busy, m_rdy); end
        checks++; if ({perr, ferr, ovr} !== {m_perr, m_ferr, m_ovr} || UARTDR !== {8'h00, m_word}) begin errors++; $display("FAIL glitch_flags: got %b %h want %b %h", {perr, ferr, ovr}, UARTDR, {m_perr, m_ferr, m_ovr}, {8'h00, m_word}); end
    endtask

    task automatic test_framing();
        logic saw;
        parity_en = 1'b0;
        send_frame(8'h55, 1'b0, 1'b0, 1'b0);
        saw = 1'b0;
        rxd = 1'b0;
        for (int i = 0; i < 40; i++) begin @(negedge clk); saw = saw | busy; end
        model_complete(8'h55, 1'b0, 1'b1, 1'b0);
        checks++; if (saw !== 1'b0) begin errors++; $display("FAIL ferr_false_start: got busy=%b want 0", saw); end
        checks++; if (UARTDR !== {8'h00, m_word} || ferr !== m_ferr || perr !== m_perr || rdy !== m_rdy) begin errors++; $display("FAIL ferr_frame: got %h f=%b p=%b r=%b want %h 1 0 1", UARTDR, ferr, perr, rdy, {8'h00, m_word}); end
        idle(8);
        checks++; if (busy !== 1'b0 || rdy !== 1'b1) begin errors++; $display("FAIL ferr_recover: got busy=%b rdy=%b want 0 1", busy, rdy); end
        pulse_ack();
        model_ack();
    endtask

    task automatic test_overrun();
        send_frame(8'h11, 1'b0, 1'b0, 1'b1);
        idle(4);
        model_complete(8'h11, 1'b0, 1'b0, 1'b0);
        send_frame(8'h22, 1'b0, 1'b0, 1'b1);
        idle(4);
        model_complete(8'h22, 1'b0, 1'b0, 1'b0);
        checks++; if (UARTDR !== {8'h00, m_word} || rdy !== m_rdy || ovr !== m_ovr) begin errors++; $display("FAIL ovr_set: got %h r=%b o=%b want %h %b %b", UARTDR, rdy, ovr, {8'h00, m_word}, m_rdy, m_ovr); end
        pulse_ack();
        model_ack();
        checks++; if (rdy !== 1'b0 || ovr !== 1'b0 || UARTDR !== 16'h0011) begin errors++; $display("FAIL ovr_ack: got r=%b o=%b %h want 0 0 0011", rdy, ovr, UARTDR); end
    endtask

    task automatic test_back_to_back();
        send_frame(8'h11, 1'b0, 1'b0, 1'b1);
        idle(4);
        model_complete(8'h11, 1'b0, 1'b0, 1'b0);
        fork
            send_frame(8'h22, 1'b0, 1'b0, 1'b1);
            begin
                @(negedge clk);
                repeat (H + 9 * B + 3) @(posedge clk);
                @(negedge clk);
                rd_ack = 1'b1;
                @(negedge clk);
                rd_ack = 1'b0;
            end
        join
        idle(4);
        model_complete(8'h22, 1'b0, 1'b0, 1'b1);
        checks++; if (UARTDR !== {8'h00, m_word} || rdy !== m_rdy || ovr !== m_ovr) begin errors++; $display("FAIL ack_coincident: got %h r=%b o=%b want %h %b %b", UARTDR, rdy, ovr, {8'h00, m_word}, m_rdy, m_ovr); end
        pulse_ack();
        model_ack();
    endtask

    task automatic test_random();
        logic [7:0] d;
        logic pe, kind, pbit, stop, skip;
        for (int n = 0; n < 10; n++) begin
            d    = 8'($urandom_range(0, 255));
            pe   = 1'($urandom_range(0, 1));
            kind = 1'($urandom_range(0, 1));
            pbit = 1'($urandom_range(0, 1));
            stop = ($urandom_range(0, 3) != 0);
            skip = ($urandom_range(0, 3) == 0);
            parity_en = pe;
            parity_kind = kind;
            send_frame(d, pe, pbit, stop);
            idle(6);
            model_complete(d, exp_perr(d, pe, kind, pbit), ~stop, 1'b0);
            checks++; if (UARTDR !== {8'h00, m_word} || perr !== m_perr || ferr !== m_ferr) begin errors++; $display("FAIL rand_frame%0d: got %h p=%b f=%b want %h %b %b", n, UARTDR, perr, ferr, {8'h00, m_word}, m_perr, m_ferr); end
            checks++; if (rdy !== m_rdy || ovr !== m_ovr || busy !== 1'b0) begin errors++; $display("FAIL rand_status%0d: got r=%b o=%b b=%b want %b %b 0", n, rdy, ovr, busy, m_rdy, m_ovr); end
            if (!skip) begin
                pulse_ack();
                model_ack();
            end
        end
        pulse_ack();
        model_ack();
        parity_en = 1'b0;
        parity_kind = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic saw;
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
        idle(4);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
        idle(4);
        @(negedge clk);
        rxd = 1'b0;
        repeat (50) @(negedge clk);
        rst_n = 1'b0;
        #1;
        m_word = 8'h00; m_rdy = 1'b0; m_perr = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
        checks++; if (UARTDR !== 16'h0000 || {rdy, perr, ferr, ovr, busy} !== 5'b00000) begin errors++; $display("FAIL reset_mid: got %h %b want 0000 00000", UARTDR, {rdy, perr, ferr, ovr, busy}); end
        @(negedge clk);
        rst_n = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < 40; i++) begin @(negedge clk); saw = saw | busy | rdy; end
        checks++; if (saw !== 1'b0) begin errors++; $display("FAIL reset_low_line: got activity=%b want 0", saw); end
        idle(10);
        send_frame(8'h96, 1'b0, 1'b0, 1'b1);
        idle(4);
        model_complete(8'h96, 1'b0, 1'b0, 1'b0);
        checks++; if (UARTDR !== {8'h00, m_word} || rdy !== m_rdy) begin errors++; $display("FAIL reset_recover: got %h r=%b want %h %b", UARTDR, rdy, {8'h00, m_word}, m_rdy); end
        pulse_ack();
        model_ack();
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_glitch();
        test_framing();
        test_overrun();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
